miriscv_lsu: RTL

- Parametrised load-store unit between the core's execute stage and the data-memory bus; it replaces direct combinational memory access.
- Accepts one load/store per instruction and drives a req/gnt/rvalid bus, holding the core (stall) until the response returns.
- Generates byte enables and replicates write data across byte lanes; on loads, extracts the addressed bytes and sign/zero-extends them.
- Detects misaligned or illegal accesses and bus timeouts.

---
 rtl/miriscv_pkg.sv | 32 +++
 rtl/miriscv_lsu_extract.sv | 30 +++
 rtl/miriscv_lsu.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/miriscv_pkg.sv
// Shared definitions for the miriscv load-store unit: size codes, FSM states and
// byte-enable generation.
package miriscv_pkg;

  localparam logic [2:0] LSU_B  = 3'd0;
  localparam logic [2:0] LSU_H  = 3'd1;
  localparam logic [2:0] LSU_W  = 3'd2;
  localparam logic [2:0] LSU_D  = 3'd3;
  localparam logic [2:0] LSU_BU = 3'd4;
  localparam logic [2:0] LSU_HU = 3'd5;
  localparam logic [2:0] LSU_WU = 3'd6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } lsu_state_e;

  // Byte enables for a 64-bit bus; narrower buses use the low bits.
  function automatic logic [7:0] be_gen(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] be;
    case (size[1:0])
      2'd0:    be = 8'h01 << off;
      2'd1:    be = 8'h03 << off;
      2'd2:    be = 8'h0F << off;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/miriscv_lsu_extract.sv
// Load-data alignment: shift the addressed bytes down to bit 0 and sign/zero-extend
// according to the size code.
module miriscv_lsu_extract
  import miriscv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned OffW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [OffW-1:0] off_i,
  input  logic [2:0]      size_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] sh;

  always_comb begin
    sh = rdata_i >> {off_i, 3'b000};
    case (size_i)
      LSU_B:   data_o = XLEN'($signed(sh[7:0]));
      LSU_H:   data_o = XLEN'($signed(sh[15:0]));
      LSU_W:   data_o = XLEN'($signed(sh[31:0]));
      LSU_BU:  data_o = XLEN'(sh[7:0]);
      LSU_HU:  data_o = XLEN'(sh[15:0]);
      LSU_WU:  data_o = XLEN'(sh[31:0]);
      default: data_o = sh;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// Load-store unit: turns one core load/store into a req/gnt/rvalid bus transaction,
// stalling the core until the response (or a timeout) arrives.
module miriscv_lsu
  import miriscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              lsu_stall_req_o,
  output logic              lsu_fault_o,
  output logic              lsu_err_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [XLEN/8-1:0] data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i
);

  localparam int unsigned BeW  = XLEN / 8;
  localparam int unsigned OffW = $clog2(BeW);
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [OffW-1:0]   off_q, off_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [BeW-1:0]    be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [OffW-1:0]   off;
  logic [2:0]        off3;
  logic              illegal, misaligned, fault;
  logic [7:0]        be_full;
  logic [XLEN-1:0]   wdata_rep, ext_data;
  logic              timeout_hit;

  assign off = lsu_addr_i[OffW-1:0];

  always_comb begin
    off3 = '0;
    off3[OffW-1:0] = off;
  end

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (lsu_size_i)
      LSU_B, LSU_BU: misaligned = 1'b0;
      LSU_H, LSU_HU: misaligned = lsu_addr_i[0];
      LSU_W, LSU_WU: misaligned = |lsu_addr_i[1:0];
      LSU_D:         misaligned = |lsu_addr_i[2:0];
      default:       illegal    = 1'b1;
    endcase
    if (XLEN == 32 && (lsu_size_i == LSU_D || lsu_size_i == LSU_WU)) illegal = 1'b1;
    // Stores have no unsigned variants.
    if (lsu_we_i && lsu_size_i[2]) illegal = 1'b1;
  end

  assign fault           = lsu_req_i & (illegal | misaligned) & (state_q == StIdle);
  assign lsu_fault_o     = fault;
  assign lsu_stall_req_o = lsu_req_i & ~fault & (state_q != StResp);

  always_comb begin
    case (lsu_size_i[1:0])
      2'd0:    wdata_rep = {BeW{lsu_wdata_i[7:0]}};
      2'd1:    wdata_rep = {(XLEN / 16){lsu_wdata_i[15:0]}};
      2'd2:    wdata_rep = {(XLEN / 32){lsu_wdata_i[31:0]}};
      default: wdata_rep = lsu_wdata_i;
    endcase
  end

  assign be_full     = be_gen(lsu_size_i, off3);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  miriscv_lsu_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .rdata_i (data_rdata_i),
    .off_i   (off_q),
    .size_i  (size_q),
    .data_o  (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    off_d   = off_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (lsu_req_i && !fault) begin
          state_d = StReq;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = lsu_we_i;
          be_d    = be_full[BeW-1:0];
          addr_d  = {lsu_addr_i[ADDR_W-1:OffW], {OffW{1'b0}}};
          wdata_d = wdata_rep;
          size_d  = lsu_size_i;
          off_d   = off;
        end
      end
      StReq: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout_hit) begin
          state_d = StResp;
          req_d   = 1'b0;
          be_d    = '0;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (data_gnt_i) begin
          // A same-cycle rvalid is a protocol violation and is dropped here.
          state_d = StWait;
          req_d   = 1'b0;
          be_d    = '0;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout_hit) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (data_rvalid_i) begin
          state_d = StResp;
          if (!we_q) rdata_d = ext_data;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      size_q  <= '0;
      off_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign data_req_o   = req_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
  assign lsu_rdata_o  = rdata_q;
  assign lsu_err_o    = err_q;

endmodule
